// File: rtl/id_queue_pkg.sv
// id_queue_pkg: configuration and payload layout shared by ID, id_queue and ROB.
// Holds the default queue depth, the decoded-instruction field widths,
// the packed payload struct and the pack/unpack helpers, so that ID and ROB
// agree on a single bit layout.
package id_queue_pkg;

  localparam int unsigned IDQ_DEPTH_DEFAULT = 4;

  // Field widths of the ID output bus
  localparam int unsigned IDQ_PC_W    = 32;
  localparam int unsigned IDQ_OPND_W  = 32;
  localparam int unsigned IDQ_REG_W   = 6;   // wr_en + wr_addr[4:0]
  localparam int unsigned IDQ_BR_W    = 2;   // is_branch + in_delayslot
  localparam int unsigned IDQ_MEM_W   = 4;   // mem_en + mem_we + mem_size[1:0]
  localparam int unsigned IDQ_EXC_W   = 6;   // exc_valid + exc_code[4:0]
  localparam int unsigned IDQ_OPGEN_W = 14;

  localparam int unsigned IDQ_DATA_WIDTH = IDQ_PC_W + 2 * IDQ_OPND_W + IDQ_REG_W +
                                           IDQ_BR_W + IDQ_MEM_W + IDQ_EXC_W + IDQ_OPGEN_W;

  typedef struct packed {
    logic [IDQ_REG_W-1:0]   reg_info;
    logic [IDQ_BR_W-1:0]    br_info;
    logic [IDQ_MEM_W-1:0]   mem_info;
    logic [IDQ_EXC_W-1:0]   exc_info;
    logic [IDQ_OPGEN_W-1:0] opgen;
    logic [IDQ_OPND_W-1:0]  opnd1;
    logic [IDQ_OPND_W-1:0]  opnd2;
    logic [IDQ_PC_W-1:0]    pc;
  } idq_payload_t;

  // Flatten a decoded instruction into the queue payload
  function automatic logic [IDQ_DATA_WIDTH-1:0] idq_pack(input idq_payload_t p);
    return IDQ_DATA_WIDTH'(p);
  endfunction

  // Recover the decoded instruction fields from a queue payload
  function automatic idq_payload_t idq_unpack(input logic [IDQ_DATA_WIDTH-1:0] d);
    return idq_payload_t'(d);
  endfunction

endpackage

// File: rtl/idq_storage.sv
// idq_storage: DEPTH x DATA_WIDTH register array for id_queue.
// One synchronous write port, one asynchronous read port; contents are
// cleared on reset only (flush leaves stale payloads in place).
// Ports: clk, rst (sync, active-low), wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module idq_storage #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 128,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/id_queue.sv
// id_queue: decoded-instruction FIFO between the ID and ROB stages.
// Buffers up to DEPTH opaque payloads with valid/ready on both sides,
// tracks whether the next decoded instruction is a delay slot, and
// supports a synchronous flush.
// Ports: clk, rst (sync, active-low), flush,
//        in_valid/in_ready/in_data/in_is_next_delayslot (from ID),
//        out_valid/out_ready/out_data (to ROB),
//        is_current_delayslot (to ID), count (occupancy).
// Build option: define IDQ_BYPASS_EN to let an instruction arriving at an
// empty queue reach the ROB combinationally in the same cycle.
module id_queue
  import id_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IDQ_DATA_WIDTH,
  parameter int unsigned DEPTH      = IDQ_DEPTH_DEFAULT,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_is_next_delayslot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  is_current_delayslot,
  output logic [CNT_W-1:0]      count
);

  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;
  logic                  delayslot_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  push;
  logic                  bypass;
  logic                  wr_en;
  logic                  rd_en;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CNT_W'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;

`ifdef IDQ_BYPASS_EN
  // Empty queue forwards ID straight to ROB; a taken pass-through is not stored
  assign out_valid = empty ? (in_valid && !flush) : 1'b1;
  assign out_data  = empty ? in_data : rd_data;
  assign bypass    = empty && push && out_ready;
`else
  assign out_valid = !empty;
  assign out_data  = rd_data;
  assign bypass    = 1'b0;
`endif

  // Storage-side transfers; push already excludes flush through in_ready
  assign wr_en = push && !bypass;
  assign rd_en = !empty && out_ready && !flush;

  // Pointers, occupancy and delay-slot tracking; flush and reset win over traffic
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      delayslot_q <= 1'b0;
    end else begin
      if (wr_en) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (rd_en) begin
        head_q <= head_q + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!wr_en && rd_en) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (push) begin
        delayslot_q <= in_is_next_delayslot;
      end
    end
  end

  idq_storage #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (tail_q),
    .wr_data (in_data),
    .rd_addr (head_q),
    .rd_data (rd_data)
  );

  assign is_current_delayslot = delayslot_q;
  assign count                = count_q;

endmodule

// File: tb/tb_id_queue.sv
// tb_id_queue: directed and randomized checks of id_queue (DEPTH=4,
// DATA_WIDTH=32) against a queue-based reference model.
module tb_id_queue;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 4;
  localparam int unsigned CW  = $clog2(DEP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_is_next_delayslot;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          is_current_delayslot;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          mds;
  logic [DW-1:0] got[$];

  always #5 clk = ~clk;

  id_queue #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_data              (in_data),
    .in_is_next_delayslot (in_is_next_delayslot),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .is_current_delayslot (is_current_delayslot),
    .count                (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ids,
                      input logic ordy, input logic fl);
    int   n;
    logic e_ir;
    logic e_ov;
    logic do_push;
    logic do_pop;
    in_valid = iv; in_data = d; in_is_next_delayslot = ids;
    out_ready = ordy; flush = fl;
    #2;
    n    = mq.size();
    e_ir = (n < int'(DEP)) && !fl;
`ifdef IDQ_BYPASS_EN
    e_ov = (n == 0) ? (iv && !fl) : 1'b1;
`else
    e_ov = (n != 0);
`endif
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("count", 32'(count), 32'(n));
    chk("delayslot", 32'(is_current_delayslot), 32'(mds));
    if (e_ov) chk("out_data", out_data, (n == 0) ? d : mq[0]);
    if (out_valid && ordy && !fl) got.push_back(out_data);
    do_push = iv && e_ir;
    do_pop  = e_ov && ordy;
    if (fl) begin
      mq.delete();
      mds = 1'b0;
    end else begin
      if (do_pop && n == 0) begin
        // instruction passes straight through an empty queue
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
      end
      if (do_push) mds = ids;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_is_next_delayslot = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    mds = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_delayslot", 32'(is_current_delayslot), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] fill_vals [4];
    fill_vals[0] = 32'h90001234; fill_vals[1] = 32'hac001234;
    fill_vals[2] = 32'h0c123456; fill_vals[3] = 32'h00005009;

    // Reset state
    do_reset();

    // Fill then drain in order
    for (int i = 0; i < 4; i++) step(1'b1, fill_vals[i], 1'b0, 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    in_valid = 1'b1; #1;
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    got.delete();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("drain_n", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("drain_order", got[i], fill_vals[i]);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Full queue with simultaneous push attempt and pop
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i + 100), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0aaa, 1'b0, 1'b1, 1'b0);
    chk("full_pop_count", 32'(count), 32'd3);
    step(1'b1, 32'h0000_0bbb, 1'b0, 1'b1, 1'b0);
    chk("push_pop_count", 32'(count), 32'd3);

    // Wrap-around: 10 push/pop pairs
    do_reset();
    got.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("wrap_n", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("wrap_order", got[i], 32'(i));

    // Delay slot tracking
    step(1'b1, 32'h14001234, 1'b1, 1'b0, 1'b0);
    chk("ds_set", 32'(is_current_delayslot), 32'd1);
    step(1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0);
    chk("ds_clr", 32'(is_current_delayslot), 32'd0);

    // Flush with simultaneous push at count=3
    step(1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd3);
    step(1'b1, 32'hdeadbeef, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_ds", 32'(is_current_delayslot), 32'd0);
    got.delete();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("flush_no_out", 32'(got.size()), 32'd0);

    // Reset mid-stream at count=2
    step(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    do_reset();

`ifdef IDQ_BYPASS_EN
    // Zero-latency pass-through on an empty queue
    in_valid = 1'b1; in_data = 32'h2408cdef; out_ready = 1'b1; flush = 1'b0;
    in_is_next_delayslot = 1'b0;
    #1;
    chk("byp_out_valid", 32'(out_valid), 32'd1);
    chk("byp_out_data", out_data, 32'h2408cdef);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_out_valid_after", 32'(out_valid), 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
